// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S master frame sequencer.
package i2s_pkg;

  localparam int SLOT_BITS_DEF = 32;

  localparam logic [1:0] WL_8  = 2'b00;
  localparam logic [1:0] WL_16 = 2'b01;
  localparam logic [1:0] WL_24 = 2'b10;
  localparam logic [1:0] WL_32 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Data bits per slot for a word_len code: 8, 16, 24 or 32.
  function automatic logic [5:0] word_bits(input logic [1:0] wl);
    return {1'b0, wl, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/i2s_sck_div.sv
// SCK generator: half-period counter, sck register and edge strobes.
// Strobes fire in the pclk cycle before sck changes level.
module i2s_sck_div #(
  parameter int DIV_W = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] clk_div,
  output logic             sck,
  output logic             rise,
  output logic             fall
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             term;

  // Count 0..clk_div while enabled; toggle sck at terminal count.
  always_comb begin
    term  = en && (cnt_q == clk_div);
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (clr) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (en) begin
      if (term) begin
        cnt_d = '0;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
    rise = term && !sck_q;
    fall = term &&  sck_q;
  end

  // Divider state registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Master-mode I2S frame sequencer: SCK/WS generation, per-bit strobes,
// slot-boundary FIFO scheduling and sticky underrun/overrun flags.
import i2s_pkg::*;

module i2s_frame_ctrl #(
  parameter int DIV_W     = 8,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             ctrl_en,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [1:0]       word_len,
  input  logic             mono,
  input  logic             flag_clr,
  input  logic             tx_empty,
  input  logic             rx_full,
  output logic             tx_ren,
  output logic             tx_load,
  output logic             tx_load_zero,
  output logic             shift_tick,
  output logic             sample_tick,
  output logic             bit_active,
  output logic             rx_wen,
  output logic             sck,
  output logic             ws,
  output logic             underrun,
  output logic             overrun,
  output logic             busy
);

  localparam int             BW     = $clog2(SLOT_BITS);
  localparam logic [BW-1:0]  B_LAST = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0]  B_PRE  = BW'(SLOT_BITS - 2);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       wl_q, wl_d;
  logic             mono_q, mono_d;
  logic [BW-1:0]    b_q, b_d;
  logic             slot_q, slot_d;     // 0 = left, 1 = right
  logic             ws_q, ws_d;
  logic             first_q, first_d;   // first RUN cycle: bit 0 drive, no SCK edge
  logic             stop_q, stop_d;     // end of this right slot returns to IDLE
  logic             zero_q, zero_d;     // pending load is zero-filled
  logic             rx_pend_q, rx_pend_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;

  logic       run, rise, fall, wrap, to_last, stop_now, fetch, ur_set;
  logic [5:0] bits;

  assign run = (state_q == ST_RUN);

  i2s_sck_div #(.DIV_W(DIV_W)) u_div (
    .pclk    (pclk),
    .preset  (preset),
    .en      (run && !first_q),
    .clr     (!run),
    .clk_div (div_q),
    .sck     (sck),
    .rise    (rise),
    .fall    (fall)
  );

  // Next-state, slot/bit bookkeeping and strobe decode.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    wl_d         = wl_q;
    mono_d       = mono_q;
    b_d          = b_q;
    slot_d       = slot_q;
    ws_d         = ws_q;
    first_d      = 1'b0;
    stop_d       = stop_q;
    zero_d       = zero_q;
    rx_pend_d    = 1'b0;
    ur_set       = 1'b0;
    tx_ren       = 1'b0;
    tx_load      = 1'b0;
    tx_load_zero = 1'b0;
    shift_tick   = 1'b0;
    sample_tick  = 1'b0;
    bit_active   = 1'b0;

    bits     = word_bits(wl_q);
    wrap     = run && fall && (b_q == B_LAST);
    to_last  = run && fall && (b_q == B_PRE);
    stop_now = wrap && stop_q;
    // Left slot end skips the fetch in mono; right slot end skips it when stopping.
    fetch    = to_last && !(slot_q ? !ctrl_en : mono_q);

    case (state_q)
      ST_IDLE: begin
        ws_d = 1'b0;
        if (ctrl_en) begin
          state_d = ST_FETCH;
          div_d   = clk_div;
          wl_d    = word_len;
          mono_d  = mono;
        end
      end
      ST_FETCH: begin
        tx_ren  = !tx_empty;
        ur_set  = tx_empty;
        zero_d  = tx_empty;
        b_d     = '0;
        slot_d  = 1'b0;
        ws_d    = 1'b0;
        stop_d  = 1'b0;
        first_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        shift_tick   = (first_q || fall) && !stop_now;
        sample_tick  = rise;
        bit_active   = 32'(b_q) < 32'(bits);
        tx_load      = shift_tick && (first_q || wrap);
        tx_load_zero = tx_load && zero_q && !(mono_q && wrap && !slot_q);
        tx_ren       = fetch && !tx_empty;
        if (fetch) begin
          ur_set = tx_empty;
          zero_d = tx_empty;
        end
        if (to_last) begin
          ws_d = ~ws_q;
          if (slot_q) stop_d = !ctrl_en;
        end
        if (fall) b_d = wrap ? '0 : b_q + BW'(1);
        if (wrap) slot_d = ~slot_q;
        rx_pend_d = rise && (b_q == BW'(bits - 6'd1)) && !(mono_q && slot_q);
        if (stop_now) begin
          state_d = ST_IDLE;
          ws_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Rx write lands one cycle after the last data bit is sampled.
    rx_wen     = rx_pend_q && !rx_full;
    underrun_d = (underrun_q && !flag_clr) || ur_set;
    overrun_d  = (overrun_q && !flag_clr) || (rx_pend_q && rx_full);
  end

  // State and flag registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      wl_q       <= '0;
      mono_q     <= 1'b0;
      b_q        <= '0;
      slot_q     <= 1'b0;
      ws_q       <= 1'b0;
      first_q    <= 1'b0;
      stop_q     <= 1'b0;
      zero_q     <= 1'b0;
      rx_pend_q  <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      wl_q       <= wl_d;
      mono_q     <= mono_d;
      b_q        <= b_d;
      slot_q     <= slot_d;
      ws_q       <= ws_d;
      first_q    <= first_d;
      stop_q     <= stop_d;
      zero_q     <= zero_d;
      rx_pend_q  <= rx_pend_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ws       = ws_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl. Time base: R0 = first RUN cycle;
// the bench is positioned 1ns after each pclk rising edge.
module tb_i2s_frame_ctrl;

  localparam int DIV_W = 8;

  logic             pclk = 1'b0;
  logic             preset, ctrl_en, mono, flag_clr, tx_empty, rx_full;
  logic [DIV_W-1:0] clk_div;
  logic [1:0]       word_len;
  logic tx_ren, tx_load, tx_load_zero, shift_tick, sample_tick, bit_active;
  logic rx_wen, sck, ws, underrun, overrun, busy;

  int n_asrt = 0;
  int n_fail = 0;
  int r = 0;
  int n_shift = 0, n_samp = 0, n_ren = 0, n_wen = 0, n_load = 0, n_ws = 0;
  int s_shift, s_samp, s_ren, s_wen, s_load, s_ws;
  logic ws_prev = 1'b0;

  always #5 pclk = ~pclk;

  i2s_frame_ctrl #(.DIV_W(DIV_W), .SLOT_BITS(32)) dut (
    .pclk(pclk), .preset(preset), .ctrl_en(ctrl_en), .clk_div(clk_div),
    .word_len(word_len), .mono(mono), .flag_clr(flag_clr),
    .tx_empty(tx_empty), .rx_full(rx_full), .tx_ren(tx_ren),
    .tx_load(tx_load), .tx_load_zero(tx_load_zero), .shift_tick(shift_tick),
    .sample_tick(sample_tick), .bit_active(bit_active), .rx_wen(rx_wen),
    .sck(sck), .ws(ws), .underrun(underrun), .overrun(overrun), .busy(busy)
  );

  // Event counters sampled mid-cycle.
  always @(negedge pclk) begin
    if (shift_tick)  n_shift <= n_shift + 1;
    if (sample_tick) n_samp  <= n_samp + 1;
    if (tx_ren)      n_ren   <= n_ren + 1;
    if (rx_wen)      n_wen   <= n_wen + 1;
    if (tx_load)     n_load  <= n_load + 1;
    if (ws != ws_prev) n_ws  <= n_ws + 1;
    ws_prev <= ws;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin @(posedge pclk); #1; r++; end
  endtask

  task automatic at(input int t);
    while (r < t) begin @(posedge pclk); #1; r++; end
  endtask

  task automatic snap();
    s_shift = n_shift; s_samp = n_samp; s_ren = n_ren;
    s_wen = n_wen; s_load = n_load; s_ws = n_ws;
  endtask

  function automatic logic [11:0] outs();
    return {sck, ws, busy, underrun, overrun, tx_ren, tx_load, tx_load_zero,
            shift_tick, sample_tick, bit_active, rx_wen};
  endfunction

  task automatic do_reset();
    preset = 1'b1; ctrl_en = 1'b0; flag_clr = 1'b0; rx_full = 1'b0; tx_empty = 1'b0;
    adv(2);
    preset = 1'b0;
    adv(1);
  endtask

  // Request start, check FETCH, scramble config inputs to prove they were latched,
  // and leave the bench at R0.
  task automatic start(input logic [7:0] d, input logic [1:0] wl, input logic m, input logic exp_ren);
    clk_div = d; word_len = wl; mono = m; ctrl_en = 1'b1;
    @(posedge pclk); #1;
    chk("fetch_busy", busy, 1);
    chk("fetch_ren", tx_ren, exp_ren);
    clk_div = 8'hff; word_len = ~wl; mono = ~m;
    @(posedge pclk); #1;
    r = 0;
    snap();
    chk("r0_load", {tx_load, shift_tick, sample_tick}, 3'b110);
  endtask

  initial begin
    preset = 1'b1; ctrl_en = 1'b0; mono = 1'b0; flag_clr = 1'b0;
    tx_empty = 1'b0; rx_full = 1'b0; clk_div = '0; word_len = '0;
    adv(3);
    chk("reset_outs", outs(), 12'h000);
    preset = 1'b0;
    adv(2);
    chk("idle_outs", outs(), 12'h000);

    // Stereo, clk_div=1 (SCK period 4), 16-bit words.
    start(8'd1, 2'b01, 1'b0, 1'b1);
    chk("st_r0_zero", tx_load_zero, 0);
    at(2);   chk("st_first_sample", {sample_tick, sck}, 2'b10);
    at(3);   chk("st_sck_high", sck, 1);
    at(62);  chk("st_samp15", {sample_tick, bit_active, rx_wen}, 3'b110);
    at(63);  chk("st_wen_left", rx_wen, 1);
    at(66);  chk("st_bit16_inactive", bit_active, 0);
    at(124); chk("st_left_end", {tx_ren, shift_tick, ws}, 3'b110);
    at(125); chk("st_ws_right", ws, 1);
    at(128); chk("st_right_load", {tx_load, tx_load_zero, ws}, 3'b101);
    at(256);
    chk("st_n_shift", n_shift - s_shift, 64);
    chk("st_n_samp", n_samp - s_samp, 64);
    chk("st_n_ren", n_ren - s_ren, 2);
    chk("st_n_wen", n_wen - s_wen, 2);
    chk("st_n_load", n_load - s_load, 2);
    chk("st_n_ws", n_ws - s_ws, 2);
    // Reset on the cycle whose successor would carry rx_wen.
    at(318); chk("rst_pre_samp", sample_tick, 1);
    preset = 1'b1; ctrl_en = 1'b0;
    adv(1);
    chk("rst_mid_run", outs(), 12'h000);
    preset = 1'b0;
    adv(1);
    chk("rst_stays_idle", busy, 0);

    // Underrun with zero-fill; flag_clr and coincident set.
    tx_empty = 1'b1;
    start(8'd1, 2'b01, 1'b0, 1'b0);
    chk("ur_r0", {tx_load_zero, underrun}, 2'b11);
    at(1);   flag_clr = 1'b1;
    at(2);   flag_clr = 1'b0; chk("ur_cleared", underrun, 0);
    at(124); flag_clr = 1'b1; chk("ur_no_ren", tx_ren, 0);
    at(125); flag_clr = 1'b0; chk("ur_set_wins", underrun, 1);
    at(128); chk("ur_zero_load", {tx_load, tx_load_zero}, 2'b11);
    chk("ur_n_ren", n_ren - s_ren, 0);
    do_reset();

    // Overrun on left word, right slot writes normally.
    start(8'd1, 2'b01, 1'b0, 1'b1);
    at(60);  rx_full = 1'b1;
    at(63);  chk("ov_dropped", {rx_wen, overrun}, 2'b00);
    at(64);  rx_full = 1'b0; chk("ov_flag", overrun, 1);
    at(191); chk("ov_right_wen", {rx_wen, overrun}, 2'b11);
    do_reset();

    // Mono, 32-bit words.
    start(8'd1, 2'b11, 1'b1, 1'b1);
    at(124); chk("mo_no_left_fetch", {tx_ren, shift_tick}, 2'b01);
    at(127); chk("mo_wen", rx_wen, 1);
    at(128); chk("mo_reload", {tx_load, tx_load_zero}, 2'b10);
    at(252); chk("mo_right_fetch", tx_ren, 1);
    at(256);
    chk("mo_n_ren", n_ren - s_ren, 1);
    chk("mo_n_wen", n_wen - s_wen, 1);
    do_reset();

    // Stop request mid-left slot at clk_div=0 (SCK period 2).
    start(8'd0, 2'b01, 1'b0, 1'b1);
    at(1);   chk("sp_first_sample", sample_tick, 1);
    at(20);  ctrl_en = 1'b0;
    at(126); chk("sp_right_end_busy", {busy, shift_tick}, 2'b11);
    at(128); chk("sp_stop_cycle", {busy, tx_ren, tx_load, shift_tick}, 4'b1000);
    at(129); chk("sp_idle", {busy, sck, ws}, 3'b000);
    at(131);
    chk("sp_n_shift", n_shift - s_shift, 64);
    chk("sp_n_wen", n_wen - s_wen, 2);
    chk("sp_n_ren", n_ren - s_ren, 1);
    chk("sp_idle_outs", outs(), 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
